evict_write_buffer: RTL
=======================

Name: evict_write_buffer

Overview:
- One-entry eviction write buffer between the set-associative cache controller's physical-memory port and physical memory.
- Absorbs a dirty-line writeback in 2 cycles so the cache can proceed straight to its line fill.
- Drains the buffered line to memory when no read is pending, and forwards the buffered line on a read that hits it.

Parameters:
- ADDR_WIDTH, 16, byte address width.
- LINE_WIDTH, 128, cache line width in bits.
- OFFSET_BITS, 4, line offset bits; the line tag is addr[ADDR_WIDTH-1:OFFSET_BITS].

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpmem_address  in  ADDR_WIDTH  cache-side request address.
- cpmem_read  in  1  cache-side line read request, held until cpmem_resp.
- cpmem_write  in  1  cache-side line write (eviction), held until cpmem_resp.
- cpmem_wdata  in  LINE_WIDTH  eviction line data.
- cpmem_rdata  out  LINE_WIDTH  read line data, valid while cpmem_resp=1.
- cpmem_resp  out  1  one-cycle completion pulse to cache.
- pmem_address  out  ADDR_WIDTH  memory address, line aligned (low OFFSET_BITS zero).
- pmem_read  out  1  memory read strobe.
- pmem_write  out  1  memory write strobe.
- pmem_wdata  out  LINE_WIDTH  memory write data.
- pmem_rdata  in  LINE_WIDTH  memory read data, valid with pmem_resp.
- pmem_resp  in  1  memory completion.

Behaviour:
- Storage: buf_valid, buf_tag, buf_data; registered rdata_q drives cpmem_rdata.
- Reset (async):
  - State = IDLE; buf_valid=0; buf_tag=0; buf_data=0; rdata_q=0.
  - All strobes 0: cpmem_resp, pmem_read, pmem_write.
  - A reset in mid-transaction drops the strobes immediately. Any buffered line is discarded.
- States: IDLE, READ_MEM, DRAIN, RESP.
- IDLE, priority order, evaluated each cycle:
  1. cpmem_write & (!buf_valid | tag hit): load buf_tag/buf_data, set buf_valid, go to RESP. A tag hit overwrites in place.
  2. cpmem_write & buf_valid & tag miss: go to DRAIN. The write is accepted after the drain completes.
  3. cpmem_read & buf_valid & tag hit: rdata_q <= buf_data, go to RESP. buf_valid stays 1.
  4. cpmem_read otherwise: go to READ_MEM.
  5. No request & buf_valid: go to DRAIN.
  6. Otherwise stay in IDLE.
- READ_MEM:
  - Drive pmem_read=1 and pmem_address={cpmem_address tag, zeros}.
  - On pmem_resp: rdata_q <= pmem_rdata, go to RESP.
- DRAIN:
  - Drive pmem_write=1, pmem_address={buf_tag, zeros}, pmem_wdata=buf_data.
  - On pmem_resp: buf_valid <= 0, go to IDLE.
  - A drain is never aborted. Cache requests arriving during a drain wait.
- RESP: cpmem_resp=1 for exactly one cycle, then go to IDLE. The request seen in the following IDLE cycle is treated as a new request.
- Latencies, counted from the first cycle a request is seen in IDLE:
  - Buffered write or forwarded read: cpmem_resp in cycle +1.
  - Memory read: cpmem_resp one cycle after pmem_resp.
- Outside their active states:
  - pmem_address and pmem_wdata are don't-care; drive {buf_tag, zeros} and buf_data.
  - cpmem_rdata holds its last value.
- Ordering: a read to a line held in the buffer is never served from memory, so a stale line is never returned.
- cpmem_read & cpmem_write together is illegal. The design treats it as a write, and the bench asserts it never occurs.
- The strobes to memory are Moore outputs of the state. There is no combinational path from cpmem_* to pmem_read/pmem_write.

Test Plan:
- Reset, then write 0x1230 with data A:
  - cpmem_resp=1 one cycle after the request.
  - No pmem activity until the request drops; then DRAIN shows pmem_write=1, addr 0x1230, data A.
  - buf_valid=0 after pmem_resp.
- Write 0x1230 A, then immediately read 0x4560:
  - Sequence is pmem_read at 0x4560, then cpmem_resp with pmem_rdata, then drain of A. The read is prioritized over the drain.
- Write 0x1230 A, then read 0x1238:
  - Forwarding: cpmem_rdata=A with resp the next cycle.
  - pmem_read never asserted.
  - The line is still drained later.
- Write 0x1230 A, then write 0x1230 B with memory stalled:
  - Second resp in 2 cycles with no drain between.
  - The final drain writes B only.
- Write 0x1230 A, hold memory off, then write 0x7770 C:
  - Drain A completes first; C is accepted after.
  - cpmem_resp is delayed until then.
  - Memory sees A, then C.
- Assert reset during DRAIN with pmem_resp low:
  - pmem_write=0 immediately.
  - After release: IDLE, buf_valid=0, no memory write issued.

Source files
------------

// File: rtl/evict_write_buffer.sv
// rtl/evict_write_buffer.sv - one-entry eviction write buffer between cache controller and physical memory
// Absorbs one dirty line, forwards it on read hits and drains it when memory is otherwise idle.
module evict_write_buffer #(
    parameter int ADDR_WIDTH  = 16,
    parameter int LINE_WIDTH  = 128,
    parameter int OFFSET_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cpmem_address,
    input  logic                  cpmem_read,
    input  logic                  cpmem_write,
    input  logic [LINE_WIDTH-1:0] cpmem_wdata,
    output logic [LINE_WIDTH-1:0] cpmem_rdata,
    output logic                  cpmem_resp,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    localparam int TAG_WIDTH = ADDR_WIDTH - OFFSET_BITS;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READ_MEM = 2'd1,
        DRAIN    = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  buf_valid;
    logic [TAG_WIDTH-1:0]  buf_tag;
    logic [LINE_WIDTH-1:0] buf_data;
    logic [LINE_WIDTH-1:0] rdata_q;

    logic [TAG_WIDTH-1:0]  req_tag;
    logic                  tag_hit;
    logic                  load_buf;
    logic                  clear_valid;
    logic                  fwd_rdata;
    logic                  mem_rdata;

    assign req_tag = cpmem_address[ADDR_WIDTH-1:OFFSET_BITS];
    assign tag_hit = (buf_tag == req_tag);

    always_comb begin
        state_next  = state;
        load_buf    = 1'b0;
        clear_valid = 1'b0;
        fwd_rdata   = 1'b0;
        mem_rdata   = 1'b0;
        unique case (state)
            IDLE: begin
                // Write wins over a simultaneous read, so an illegal read+write acts as a write.
                if (cpmem_write && (!buf_valid || tag_hit)) begin
                    load_buf   = 1'b1;
                    state_next = RESP;
                end else if (cpmem_write) begin
                    state_next = DRAIN;
                end else if (cpmem_read && buf_valid && tag_hit) begin
                    fwd_rdata  = 1'b1;
                    state_next = RESP;
                end else if (cpmem_read) begin
                    state_next = READ_MEM;
                end else if (buf_valid) begin
                    state_next = DRAIN;
                end
            end
            READ_MEM: begin
                if (pmem_resp) begin
                    mem_rdata  = 1'b1;
                    state_next = RESP;
                end
            end
            DRAIN: begin
                if (pmem_resp) begin
                    clear_valid = 1'b1;
                    state_next  = IDLE;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
            rdata_q   <= '0;
        end else begin
            state <= state_next;
            if (load_buf) begin
                buf_valid <= 1'b1;
                buf_tag   <= req_tag;
                buf_data  <= cpmem_wdata;
            end else if (clear_valid) begin
                buf_valid <= 1'b0;
            end
            if (fwd_rdata) begin
                rdata_q <= buf_data;
            end else if (mem_rdata) begin
                rdata_q <= pmem_rdata;
            end
        end
    end

    // Strobes decode the state only; the address mux is the sole path from cpmem_* to pmem_*.
    assign pmem_read    = (state == READ_MEM);
    assign pmem_write   = (state == DRAIN);
    assign cpmem_resp   = (state == RESP);
    assign pmem_address = (state == READ_MEM) ? {req_tag, {OFFSET_BITS{1'b0}}}
                                              : {buf_tag, {OFFSET_BITS{1'b0}}};
    assign pmem_wdata   = buf_data;
    assign cpmem_rdata  = rdata_q;

endmodule
